dcnn_out_packer: RTL and testbench

DCNN_OUT_PACKER -- requirements
Module: dcnn_out_packer

---
 rtl/dcnn_out_packer.sv | 159 +++++++++++++++
 tb/tb_dcnn_out_packer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcnn_out_packer.sv
// dcnn_out_packer: collects DW-bit core output words into IODW-bit IO beats.
// Words fill lanes starting at lane 0, which lands in bits [DW-1:0]. A full
// beat goes to a registered output stage at an address that advances by a
// stride per beat. At the end of a layer a partial beat is flushed with a
// lane mask and io_last, and a single done pulse is given.
module dcnn_out_packer #(
    parameter int DW   = 32,
    parameter int IODW = 96,
    parameter int AW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic              layer_finish,
    input  logic [AW-1:0]     gp_out_addr_base,
    input  logic [AW-1:0]     gp_out_addr_stride,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DW-1:0]     in_data,
    output logic              io_vld,
    input  logic              io_rdy,
    output logic [IODW-1:0]   io_data,
    output logic [AW-1:0]     io_addr,
    output logic [IODW/DW-1:0] io_mask,
    output logic              io_last,
    output logic              done
);
    localparam int L  = IODW / DW;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(L - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PACK  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_reg;
    logic [LW-1:0]   lane_reg;
    logic [AW-1:0]   next_addr_reg;
    logic [AW-1:0]   stride_reg;
    logic [DW-1:0]   pack_reg [L];
    logic [IODW-1:0] data_reg;
    logic [AW-1:0]   addr_reg;
    logic [L-1:0]    mask_reg;
    logic            last_reg;
    logic            vld_reg;
    logic            done_reg;

    logic [IODW-1:0] full_beat;
    logic [IODW-1:0] flush_beat;
    logic [L-1:0]    flush_mask;
    logic            out_free;
    logic            accept;
    logic            load_full;
    logic            load_flush;

    // The output stage can take a new beat if empty or draining this cycle.
    assign out_free   = !vld_reg || io_rdy;
    // Only the word that completes a beat needs the output stage to be free.
    assign in_rdy     = (state_reg == S_PACK) && ((lane_reg != LANE_LAST) || out_free);
    assign accept     = in_vld && in_rdy;
    assign load_full  = accept && (lane_reg == LANE_LAST);
    assign load_flush = (state_reg == S_FLUSH) && (lane_reg != '0) && out_free;

    // Per-lane beat assembly: the full beat bypasses the last word straight
    // from in_data, and the flush beat zeroes lanes that were never written.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_lane
            if (gi == L - 1) begin : g_last
                assign full_beat[gi*DW +: DW] = in_data;
            end else begin : g_body
                assign full_beat[gi*DW +: DW] = pack_reg[gi];
            end
            assign flush_mask[gi]          = (lane_reg > LW'(gi));
            assign flush_beat[gi*DW +: DW] = flush_mask[gi] ? pack_reg[gi] : '0;
        end
    endgenerate

    // Control FSM, lane packing and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            lane_reg      <= '0;
            next_addr_reg <= '0;
            stride_reg    <= '0;
            data_reg      <= '0;
            addr_reg      <= '0;
            mask_reg      <= '0;
            last_reg      <= 1'b0;
            vld_reg       <= 1'b0;
            done_reg      <= 1'b0;
            for (int i = 0; i < L; i++) begin
                pack_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            if (vld_reg && io_rdy) begin
                vld_reg <= 1'b0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (layer_start) begin
                        state_reg     <= S_PACK;
                        lane_reg      <= '0;
                        next_addr_reg <= gp_out_addr_base;
                        stride_reg    <= gp_out_addr_stride;
                    end
                end
                S_PACK: begin
                    if (accept) begin
                        pack_reg[lane_reg] <= in_data;
                        lane_reg           <= (lane_reg == LANE_LAST) ? '0 : lane_reg + 1'b1;
                    end
                    if (load_full) begin
                        data_reg      <= full_beat;
                        addr_reg      <= next_addr_reg;
                        mask_reg      <= '1;
                        last_reg      <= 1'b0;
                        vld_reg       <= 1'b1;
                        next_addr_reg <= next_addr_reg + stride_reg;
                    end
                    if (layer_finish) begin
                        state_reg <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (lane_reg == '0) begin
                        state_reg <= S_DONE;
                    end else if (load_flush) begin
                        data_reg      <= flush_beat;
                        addr_reg      <= next_addr_reg;
                        mask_reg      <= flush_mask;
                        last_reg      <= 1'b1;
                        vld_reg       <= 1'b1;
                        next_addr_reg <= next_addr_reg + stride_reg;
                        lane_reg      <= '0;
                        state_reg     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!vld_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign io_vld  = vld_reg;
    assign io_data = data_reg;
    assign io_addr = addr_reg;
    assign io_mask = mask_reg;
    assign io_last = last_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_dcnn_out_packer.sv
// Testbench for dcnn_out_packer: stimulus pushes expected beats into a
// scoreboard queue; a monitor pops and compares every accepted IO beat.
module tb_dcnn_out_packer;
    localparam int DW   = 32;
    localparam int IODW = 96;
    localparam int AW   = 32;
    localparam int L    = IODW / DW;

    typedef struct {
        logic [IODW-1:0] data;
        logic [AW-1:0]   addr;
        logic [L-1:0]    mask;
        logic            last;
    } beat_t;

    logic            clk;
    logic            rst;
    logic            layer_start;
    logic            layer_finish;
    logic [AW-1:0]   gp_out_addr_base;
    logic [AW-1:0]   gp_out_addr_stride;
    logic            in_vld;
    logic            in_rdy;
    logic [DW-1:0]   in_data;
    logic            io_vld;
    logic            io_rdy;
    logic [IODW-1:0] io_data;
    logic [AW-1:0]   io_addr;
    logic [L-1:0]    io_mask;
    logic            io_last;
    logic            done;

    int    total = 0;
    int    bad   = 0;
    int    rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
    int    exp_done = 0;
    beat_t exp_q[$];

    dcnn_out_packer #(.DW(DW), .IODW(IODW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .layer_start(layer_start), .layer_finish(layer_finish),
        .gp_out_addr_base(gp_out_addr_base), .gp_out_addr_stride(gp_out_addr_stride),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .io_vld(io_vld), .io_rdy(io_rdy), .io_data(io_data), .io_addr(io_addr),
        .io_mask(io_mask), .io_last(io_last), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no end required end");
        $fatal(1);
    end

    // IO-side ready generator.
    initial begin
        io_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       io_rdy = 1'b1;
                1:       io_rdy = ($urandom_range(0, 3) != 0);
                default: io_rdy = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: beats, output stability under stall, done pulses.
    initial begin
        logic            prev_stall;
        logic            prev_done;
        logic [IODW-1:0] p_data;
        logic [AW-1:0]   p_addr;
        logic [L-1:0]    p_mask;
        logic            p_last;
        beat_t           e;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        p_data = '0; p_addr = '0; p_mask = '0; p_last = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                total++;
                if (!io_vld || io_data !== p_data || io_addr !== p_addr ||
                    io_mask !== p_mask || io_last !== p_last) begin
                    bad++;
                    $display("FAIL stall_hold: got vld=%b data=%h addr=%h required vld=1 data=%h addr=%h",
                             io_vld, io_data, io_addr, p_data, p_addr);
                end
            end
            if (io_vld && io_rdy && !rst) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got data=%h addr=%h mask=%b last=%b required none",
                             io_data, io_addr, io_mask, io_last);
                end else begin
                    e = exp_q.pop_front();
                    if (io_data !== e.data || io_addr !== e.addr ||
                        io_mask !== e.mask || io_last !== e.last) begin
                        bad++;
                        $display("FAIL beat: got data=%h addr=%h mask=%b last=%b required data=%h addr=%h mask=%b last=%b",
                                 io_data, io_addr, io_mask, io_last, e.data, e.addr, e.mask, e.last);
                    end
                end
            end
            if (done) begin
                total++;
                if (exp_done == 0 || prev_done) begin
                    bad++;
                    $display("FAIL done_pulse: got done=1 (pending=%0d prev=%b) required no pulse",
                             exp_done, prev_done);
                end else begin
                    exp_done--;
                end
            end
            prev_done  = done;
            prev_stall = io_vld && !io_rdy && !rst;
            p_data = io_data; p_addr = io_addr; p_mask = io_mask; p_last = io_last;
        end
    end

    // Reference model: cut the word list into L-word beats.
    task automatic push_layer(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                              input logic [DW-1:0] w[$]);
        int nb;
        nb = (w.size() + L - 1) / L;
        for (int k = 0; k < nb; k++) begin
            beat_t b;
            b.data = '0;
            b.mask = '0;
            b.addr = base + AW'(k) * stride;
            for (int i = 0; i < L; i++) begin
                if (k * L + i < w.size()) begin
                    b.data[i*DW +: DW] = w[k*L + i];
                    b.mask[i] = 1'b1;
                end
            end
            b.last = (b.mask != {L{1'b1}});
            exp_q.push_back(b);
        end
        exp_done++;
    endtask

    // Present one word until it is accepted; optionally finish on the same edge.
    task automatic send_word(input logic [DW-1:0] d, input bit fin);
        int cnt;
        bit ok;
        cnt = 0;
        ok  = 1'b0;
        in_vld  = 1'b1;
        in_data = d;
        while (!ok && cnt < 500) begin
            @(negedge clk);
            if (in_rdy) ok = 1'b1;
            else cnt++;
        end
        if (!ok) check("word_accept_timeout", 0, 1);
        if (fin) layer_finish = 1'b1;
        @(posedge clk);
        #1;
        in_vld       = 1'b0;
        layer_finish = 1'b0;
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || exp_done != 0) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("layer_drain", {exp_q.size(), exp_done}, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int n,
                             input bit rnd_words, input bit fin_with, input int gap_max,
                             input bit junk_start, input bit stall_chk);
        logic [DW-1:0] w[$];
        for (int i = 0; i < n; i++) w.push_back(rnd_words ? DW'($urandom) : DW'(i + 1));
        push_layer(base, stride, w);
        gp_out_addr_base   = base;
        gp_out_addr_stride = stride;
        layer_start        = 1'b1;
        @(posedge clk);
        #1;
        layer_start        = 1'b0;
        gp_out_addr_base   = $urandom;
        gp_out_addr_stride = $urandom;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    if (junk_start && i == 2) begin
                        layer_start = 1'b1;
                        @(posedge clk);
                        #1;
                        layer_start = 1'b0;
                    end
                    repeat ($urandom_range(0, gap_max)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_word(w[i], fin_with && (i == n - 1));
                end
            end
            begin
                if (stall_chk) begin
                    logic [IODW-1:0] first_beat;
                    first_beat = {w[2], w[1], w[0]};
                    repeat (12) @(posedge clk);
                    @(negedge clk);
                    check("stall_in_rdy", in_rdy, 0);
                    check("stall_io_vld", io_vld, 1);
                    check("stall_io_data", io_data, first_beat);
                    @(posedge clk);
                    #1;
                    rdy_mode = 0;
                end
            end
        join
        if (!fin_with) begin
            layer_finish = 1'b1;
            @(posedge clk);
            #1;
            layer_finish = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        rst = 1'b1; layer_start = 1'b0; layer_finish = 1'b0;
        gp_out_addr_base = '0; gp_out_addr_stride = '0;
        in_vld = 1'b0; in_data = '0;
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_io_vld", io_vld, 0);
        check("reset_in_rdy", in_rdy, 0);
        check("reset_done", done, 0);
        check("reset_io_data", io_data, 0);
        check("reset_io_addr", io_addr, 0);
        check("reset_io_mask", io_mask, 0);
        check("reset_io_last", io_last, 0);
        @(posedge clk);
        #1;

        rdy_mode = 0;
        run_layer(32'h0000FFFF, 32'd4, 6, 0, 0, 0, 0, 0);   // two full beats
        run_layer(32'h00001000, 32'd8, 4, 0, 0, 0, 0, 0);   // full + partial flush
        rdy_mode = 2;
        @(posedge clk);
        #1;
        run_layer(32'h00002000, 32'd16, 6, 0, 0, 0, 0, 1);  // long stall
        rdy_mode = 0;
        run_layer(32'h00003000, 32'd4, 3, 0, 1, 0, 0, 0);   // finish with 3rd word
        run_layer(32'hFFFFFFFC, 32'd4, 6, 0, 0, 0, 0, 0);   // address wrap
        run_layer(32'h00004000, 32'd12, 5, 1, 0, 2, 1, 0); // ignored mid-layer start
        run_layer(32'h00005000, 32'd4, 0, 0, 0, 0, 0, 0);   // empty layer
        rdy_mode = 1;
        for (int t = 0; t < 14; t++) begin
            int n;
            n = $urandom_range(0, 14);
            run_layer($urandom, $urandom, n, 1, (n > 0) && ($urandom_range(0, 1) == 1),
                      $urandom_range(0, 2), 0, 0);
        end

        // Reset with a stalled full beat and two words pending in the pack.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        gp_out_addr_base = 32'h500; gp_out_addr_stride = 32'd4;
        layer_start = 1'b1;
        @(posedge clk);
        #1;
        layer_start = 1'b0;
        for (int i = 1; i <= 5; i++) send_word(DW'(i), 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_reset_in_rdy", in_rdy, 0);
        check("pre_reset_io_vld", io_vld, 1);
        @(posedge clk);
        #1;
        rst = 1'b1; in_vld = 1'b1; in_data = 32'd99;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_io_vld", io_vld, 0);
        check("mid_reset_in_rdy", in_rdy, 0);
        check("mid_reset_io_mask", io_mask, 0);
        check("mid_reset_io_data", io_data, 0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        repeat (20) @(negedge clk);
        check("post_reset_in_rdy", in_rdy, 0);
        check("post_reset_io_vld", io_vld, 0);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        run_layer(32'h00006000, 32'd4, 7, 1, 0, 1, 0, 0);   // recovery

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
